// File: rtl/dm9000a_pkg.sv
// Shared definitions for the DM9000A host bus arbiter.
// Holds the bus sequencer state encoding, DM9000A register indices and
// a helper that turns a cycle-count parameter into a terminal count.
package dm9000a_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IDX_LOW = 3'd1,
    IDX_GAP = 3'd2,
    DAT_LOW = 3'd3,
    DAT_GAP = 3'd4,
    DONE    = 3'd5
  } bus_state_t;

  localparam logic [7:0] REG_NCR   = 8'h00;
  localparam logic [7:0] REG_NSR   = 8'h01;
  localparam logic [7:0] REG_TCR   = 8'h02;
  localparam logic [7:0] REG_CSCR  = 8'h31;
  localparam logic [7:0] REG_PHY   = 8'h1F;
  localparam logic [7:0] REG_MWCMD = 8'hF8;
  localparam logic [7:0] REG_TXPLL = 8'hFC;
  localparam logic [7:0] REG_TXPLH = 8'hFD;
  localparam logic [7:0] REG_ISR   = 8'hFE;
  localparam logic [7:0] REG_IMR   = 8'hFF;

  // Last count value of a phase lasting 'cycles' clocks; 0 behaves as 1.
  function automatic logic [3:0] last_count(input int unsigned cycles);
    return (cycles == 0) ? 4'd0 : 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/dm9000a_bus_arbiter_if.sv
// Requester-side handshake bundle for the DM9000A bus arbiter.
// Per requester N in {0,1}:
//   reqN_valid/write/data_only/lock/addr/wdata : request from the client
//   reqN_ready (1-cycle completion pulse), reqN_rdata : results to the client
// master = client side, slave = arbiter side.
interface dm9000a_bus_arbiter_if;
  logic        req0_valid, req0_write, req0_data_only, req0_lock;
  logic [7:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic [15:0] req0_rdata;
  logic        req1_valid, req1_write, req1_data_only, req1_lock;
  logic [7:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic [15:0] req1_rdata;

  modport master (
    output req0_valid, req0_write, req0_data_only, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_data_only, req1_lock, req1_addr, req1_wdata,
    input  req0_ready, req0_rdata, req1_ready, req1_rdata
  );

  modport slave (
    input  req0_valid, req0_write, req0_data_only, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_data_only, req1_lock, req1_addr, req1_wdata,
    output req0_ready, req0_rdata, req1_ready, req1_rdata
  );
endinterface

// File: rtl/dm9000a_rr_grant.sv
// Two-way round-robin grant with lock hold.
// Ports: clk_30, reset_n (async, active low); valid0/1, lock0/1 from the
// requesters; done marks the completion cycle of the transaction owned by
// served_id; grant_valid/grant_id give the winner for the current cycle.
module dm9000a_rr_grant (
  input  logic clk_30,
  input  logic reset_n,
  input  logic valid0,
  input  logic valid1,
  input  logic lock0,
  input  logic lock1,
  input  logic done,
  input  logic served_id,
  output logic grant_valid,
  output logic grant_id
);
  logic last_grant, lock_hold, lock_id, held;

  always_comb begin
    // A hold only stays in force while the owner keeps its lock raised.
    held        = lock_hold && (lock_id ? lock1 : lock0);
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (held) begin
      grant_id    = lock_id;
      grant_valid = lock_id ? valid1 : valid0;
    end else if (valid0 && valid1) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (valid0 || valid1) begin
      grant_valid = 1'b1;
      grant_id    = valid1;
    end
  end

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      lock_hold  <= 1'b0;
      lock_id    <= 1'b0;
    end else if (done) begin
      last_grant <= served_id;
      lock_hold  <= served_id ? lock1 : lock0;
      lock_id    <= served_id;
    end
  end
endmodule

// File: rtl/dm9000a_bus_arbiter.sv
// Shares the DM9000A 16-bit host bus between two requesters.
// Ports: clk_30, reset_n (async, active low); req (slave side of the
// requester handshake bundle); enet_ior_n/enet_iow_n strobes, enet_cmd
// (0=INDEX, 1=DATA) and the bidirectional enet_data bus.
// A transaction is an optional INDEX write of the register address
// followed by a DATA write or read, each strobe followed by a gap.
module dm9000a_bus_arbiter
  import dm9000a_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES      = 1,
  parameter int unsigned READ_PULSE_CYCLES = 2
) (
  input  logic                  clk_30,
  input  logic                  reset_n,
  dm9000a_bus_arbiter_if.slave  req,
  output logic                  enet_ior_n,
  output logic                  enet_iow_n,
  output logic                  enet_cmd,
  inout  wire  [15:0]           enet_data
);
  localparam logic [3:0] PULSE_LAST = last_count(PULSE_CYCLES);
  localparam logic [3:0] READ_LAST  = last_count(READ_PULSE_CYCLES);

  bus_state_t  state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        capture, rd_capture;
  logic        grant_valid, grant_id;
  logic        cur_id, cur_write;
  logic [7:0]  cur_addr;
  logic [15:0] cur_wdata;
  logic [15:0] rdata0, rdata1;
  logic        data_oe;
  logic [15:0] data_out;
  logic        sel_write, sel_data_only;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;

  dm9000a_rr_grant u_grant (
    .clk_30      (clk_30),
    .reset_n     (reset_n),
    .valid0      (req.req0_valid),
    .valid1      (req.req1_valid),
    .lock0       (req.req0_lock),
    .lock1       (req.req1_lock),
    .done        (state == DONE),
    .served_id   (cur_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_write     = grant_id ? req.req1_write     : req.req0_write;
  assign sel_data_only = grant_id ? req.req1_data_only : req.req0_data_only;
  assign sel_addr      = grant_id ? req.req1_addr      : req.req0_addr;
  assign sel_wdata     = grant_id ? req.req1_wdata     : req.req0_wdata;

  assign enet_data = data_oe ? data_out : 'z;

  assign req.req0_ready = (state == DONE) && !cur_id;
  assign req.req1_ready = (state == DONE) &&  cur_id;
  assign req.req0_rdata = rdata0;
  assign req.req1_rdata = rdata1;

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_id    <= 1'b0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (capture) begin
        cur_id    <= grant_id;
        cur_write <= sel_write;
        cur_addr  <= sel_addr;
        cur_wdata <= sel_wdata;
      end
      if (rd_capture) begin
        if (cur_id) rdata1 <= enet_data;
        else        rdata0 <= enet_data;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 4'd1;
    capture    = 1'b0;
    rd_capture = 1'b0;
    enet_iow_n = 1'b1;
    enet_ior_n = 1'b1;
    enet_cmd   = 1'b0;
    data_oe    = 1'b0;
    data_out   = {8'h00, cur_addr};
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (grant_valid) begin
          capture = 1'b1;
          state_d = sel_data_only ? DAT_LOW : IDX_LOW;
        end
      end
      IDX_LOW: begin
        enet_iow_n = 1'b0;
        data_oe    = 1'b1;
        if (cnt == PULSE_LAST) begin
          state_d = IDX_GAP;
          cnt_d   = '0;
        end
      end
      IDX_GAP: begin
        data_oe = 1'b1;
        if (cnt == PULSE_LAST) begin
          state_d = DAT_LOW;
          cnt_d   = '0;
        end
      end
      DAT_LOW: begin
        enet_cmd = 1'b1;
        data_out = cur_wdata;
        if (cur_write) begin
          enet_iow_n = 1'b0;
          data_oe    = 1'b1;
        end else begin
          enet_ior_n = 1'b0;
        end
        if (cnt == (cur_write ? PULSE_LAST : READ_LAST)) begin
          // Read data is sampled on the edge that releases ior_n.
          rd_capture = !cur_write;
          state_d    = DAT_GAP;
          cnt_d      = '0;
        end
      end
      DAT_GAP: begin
        enet_cmd = 1'b1;
        data_oe  = cur_write;
        data_out = cur_wdata;
        if (cnt == PULSE_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule
